// File: rtl/aidc_lite_comp_pkg.sv
// aidc_lite_comp_pkg: register map, FSM/step encodings and address helper for the AIDC-Lite driver
package aidc_lite_comp_pkg;
  localparam logic [31:0] REG_SRC = 32'h0000_0000;
  localparam logic [31:0] REG_DST = 32'h0000_0004;
  localparam logic [31:0] REG_LEN = 32'h0000_0008;
  localparam logic [31:0] REG_CTRL = 32'h0000_000C;
  localparam logic [31:0] LEN_MASK = 32'hFFFF_FF80;
  localparam logic [31:0] STAT_DONE = 32'h0000_0001;
  localparam logic [31:0] CTRL_START = 32'h0000_0001;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, GAP} state_e;
  typedef enum logic [2:0] {WR_SRC, WR_DST, WR_LEN, WR_START, RD_STAT} step_e;
  function automatic logic [31:0] step_addr(input step_e s);
    return s == WR_SRC ? REG_SRC : s == WR_DST ? REG_DST : s == WR_LEN ? REG_LEN : REG_CTRL;
  endfunction
endpackage

// File: rtl/aidc_lite_apb_if.sv
// APB_INTF: APB3 signal bundle with initiator and completer views
interface APB_INTF;
  logic psel;
  logic penable;
  logic pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic pready;
  logic pslverr;
  modport master(output psel, penable, pwrite, paddr, pwdata, input prdata, pready, pslverr);
  modport slave(input psel, penable, pwrite, paddr, pwdata, output prdata, pready, pslverr);
endinterface

// File: rtl/aidc_lite_apb_master.sv
// aidc_lite_apb_master: single-transfer APB initiator; a req on the ack cycle chains the next transfer back-to-back
module aidc_lite_apb_master
  import aidc_lite_comp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ack,
  output logic [31:0] rdata,
  output logic        slverr,
  output logic        psel,
  output logic        penable,
  output logic        pwrite,
  output logic [31:0] paddr,
  output logic [31:0] pwdata,
  input  logic [31:0] prdata,
  input  logic        pready,
  input  logic        pslverr
);
  state_e state_q, state_d;
  logic pwrite_q, pwrite_d, start;
  logic [31:0] paddr_q, paddr_d, pwdata_q, pwdata_d;
  assign ack = state_q == ACCESS && pready;
  assign rdata = prdata;
  assign slverr = pslverr;
  assign psel = state_q != IDLE;
  assign penable = state_q == ACCESS;
  assign pwrite = pwrite_q;
  assign paddr = paddr_q;
  assign pwdata = pwdata_q;
  always_comb begin
    start = req && (state_q == IDLE || ack);
    state_d = start ? SETUP : state_q == SETUP ? ACCESS : ack ? IDLE : state_q;
    paddr_d = start ? addr : ack ? '0 : paddr_q;
    pwrite_d = start ? write : ack ? 1'b0 : pwrite_q;
    pwdata_d = start ? wdata : ack ? '0 : pwdata_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pwrite_q <= 1'b0;
      paddr_q <= '0;
      pwdata_q <= '0;
    end else begin
      state_q <= state_d;
      pwrite_q <= pwrite_d;
      paddr_q <= paddr_d;
      pwdata_q <= pwdata_d;
    end
  end
endmodule

// File: rtl/aidc_lite_comp_drv.sv
// aidc_lite_comp_drv: programs SRC/DST/LEN/START over APB, polls STAT until done, and
// reports done/timeout/error as single-cycle pulses.
module aidc_lite_comp_drv
  import aidc_lite_comp_pkg::*;
#(
  parameter int POLL_GAP = 16,
  parameter int MAX_POLLS = 0
) (
  input  logic        clk,
  input  logic        rst,
  APB_INTF.master     apb_if,
  input  logic        launch_valid_i,
  output logic        launch_ready_o,
  input  logic [31:0] src_addr_i,
  input  logic [31:0] dst_addr_i,
  input  logic [31:0] len_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        timeout_o,
  output logic        err_o
);
  // Here ACCESS covers the whole bus transfer; SETUP/ACCESS phasing lives in the APB master.
  state_e state_q, state_d;
  step_e step_q, step_d;
  logic [15:0] polls_q, polls_d, polls_inc;
  logic [7:0] gap_q, gap_d;
  logic [31:0] src_q, src_d, dst_q, dst_d, len_q, len_d, addr, wdata, rdata;
  logic busy_q, busy_d, done_q, done_d, timeout_q, timeout_d, err_q, err_d;
  logic hs, ack, slverr, req, write, wr_ack, poll_miss, gap_end;
  logic psel, penable, pwrite;
  logic [31:0] paddr, pwdata;
  aidc_lite_apb_master u_apb (
    .clk(clk), .rst(rst), .req(req), .write(write), .addr(addr), .wdata(wdata),
    .ack(ack), .rdata(rdata), .slverr(slverr),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(apb_if.prdata), .pready(apb_if.pready), .pslverr(apb_if.pslverr)
  );
  assign apb_if.psel = psel;
  assign apb_if.penable = penable;
  assign apb_if.pwrite = pwrite;
  assign apb_if.paddr = paddr;
  assign apb_if.pwdata = pwdata;
  assign launch_ready_o = state_q == IDLE;
  assign busy_o = busy_q;
  assign done_o = done_q;
  assign timeout_o = timeout_q;
  assign err_o = err_q;
  always_comb begin
    hs = launch_valid_i && state_q == IDLE;
    wr_ack = ack && !slverr && step_q != RD_STAT;
    done_d = ack && !slverr && step_q == RD_STAT && (rdata & STAT_DONE) != '0;
    poll_miss = ack && !slverr && step_q == RD_STAT && (rdata & STAT_DONE) == '0;
    polls_inc = polls_q == 16'hFFFF ? polls_q : polls_q + 16'd1;
    timeout_d = poll_miss && MAX_POLLS != 0 && polls_inc == 16'(MAX_POLLS);
    err_d = ack && slverr;
    gap_end = state_q == GAP && gap_q == 8'd0;
    req = hs || wr_ack || (poll_miss && !timeout_d && POLL_GAP == 0) || gap_end;
    state_d = hs || gap_end ? ACCESS : done_d || timeout_d || err_d ? IDLE :
              poll_miss && POLL_GAP != 0 ? GAP : state_q;
    step_d = hs ? WR_SRC : wr_ack ? step_e'(step_q + 3'd1) : step_q;
    polls_d = hs ? '0 : poll_miss ? polls_inc : polls_q;
    gap_d = poll_miss ? 8'(POLL_GAP - 1) : state_q == GAP ? gap_q - 8'd1 : gap_q;
    src_d = hs ? src_addr_i : src_q;
    dst_d = hs ? dst_addr_i : dst_q;
    len_d = hs ? len_i : len_q;
    write = step_d != RD_STAT;
    addr = step_addr(step_d);
    wdata = step_d == WR_SRC ? src_d : step_d == WR_DST ? dst_q :
            step_d == WR_LEN ? (len_q & LEN_MASK) : step_d == WR_START ? CTRL_START : '0;
    busy_d = state_d != IDLE || done_d || timeout_d || err_d;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      step_q <= WR_SRC;
      polls_q <= '0;
      gap_q <= '0;
      src_q <= '0;
      dst_q <= '0;
      len_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      timeout_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q <= step_d;
      polls_q <= polls_d;
      gap_q <= gap_d;
      src_q <= src_d;
      dst_q <= dst_d;
      len_q <= len_d;
      busy_q <= busy_d;
      done_q <= done_d;
      timeout_q <= timeout_d;
      err_q <= err_d;
    end
  end
endmodule

// File: tb/tb_aidc_lite_comp_drv.sv
// tb_aidc_lite_comp_drv: directed-vector bench with an APB completer model and transfer/pulse logger
module tb_aidc_lite_comp_drv;
  logic clk = 1'b0, rst = 1'b1;
  logic launch_valid = 1'b0, launch_ready, busy, done, timeout, err;
  logic [31:0] src = '0, dst = '0, len = '0;
  APB_INTF apb ();
  aidc_lite_comp_drv #(.POLL_GAP(4), .MAX_POLLS(5)) dut (
    .clk(clk), .rst(rst), .apb_if(apb),
    .launch_valid_i(launch_valid), .launch_ready_o(launch_ready),
    .src_addr_i(src), .dst_addr_i(dst), .len_i(len),
    .busy_o(busy), .done_o(done), .timeout_o(timeout), .err_o(err)
  );
  always #5 clk = ~clk;
  int n_chk = 0, n_pass = 0;
  int wait_n = 0, done_on = 1, wcnt = 0, reads = 0;
  logic [31:0] err_addr = 32'hFFFF_FFFF;
  int edge_n = 0, t0 = 0, done_cnt = 0, to_cnt = 0, err_cnt = 0;
  int done_cyc = 0, to_cyc = 0, err_cyc = 0, busy_n = 0, unstable = 0, glen = 0, ng = 0, n_xfer = 0;
  int gaps[8];
  logic [31:0] log_addr[32], log_data[32], s_addr, s_data;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask
  initial begin
    apb.pready = 1'b0;
    apb.pslverr = 1'b0;
    apb.prdata = '0;
  end
  // completer model: wait states, done on a chosen read, slverr on a chosen address
  always @(negedge clk) begin
    if (apb.psel && apb.penable) begin
      apb.pready = wcnt == wait_n;
      wcnt = apb.pready ? 0 : wcnt + 1;
    end else begin
      apb.pready = 1'b0;
      wcnt = 0;
    end
    apb.pslverr = apb.pready && apb.paddr == err_addr;
    apb.prdata = {31'd0, done_on != 0 && reads + 1 == done_on};
  end
  always @(posedge clk) begin
    edge_n++;
    if (launch_valid && launch_ready) t0 = edge_n;
    if (done) begin done_cnt++; done_cyc = edge_n - t0; end
    if (timeout) begin to_cnt++; to_cyc = edge_n - t0; end
    if (err) begin err_cnt++; err_cyc = edge_n - t0; end
    if (busy) busy_n++;
    if (apb.psel && !apb.penable) begin s_addr = apb.paddr; s_data = apb.pwdata; end
    if (apb.psel && apb.penable && (apb.paddr != s_addr || apb.pwdata != s_data)) unstable++;
    if (apb.psel && apb.penable && apb.pready && n_xfer < 32) begin
      log_addr[n_xfer] = apb.paddr;
      log_data[n_xfer] = apb.pwrite ? apb.pwdata : apb.prdata;
      n_xfer++;
      if (!apb.pwrite) reads++;
    end
    if (busy && !apb.psel) glen++;
    else if (apb.psel && glen != 0) begin
      if (ng < 8) gaps[ng] = glen;
      ng++;
      glen = 0;
    end
  end
  task automatic run_job(input logic [31:0] s, d, l, input int w, dn, input logic [31:0] ea, input bit poke);
    @(negedge clk);
    wait_n = w; done_on = dn; err_addr = ea; reads = 0;
    done_cnt = 0; to_cnt = 0; err_cnt = 0; busy_n = 0; unstable = 0; glen = 0; ng = 0; n_xfer = 0;
    src = s; dst = d; len = l; launch_valid = 1'b1;
    @(negedge clk);
    launch_valid = 1'b0;
    src = 32'hDEAD_BEEF; dst = 32'hCAFE_F00D; len = 32'h1234_5678;
    if (poke) begin
      repeat (15) @(negedge clk);
      launch_valid = 1'b1;
      @(negedge clk);
      launch_valid = 1'b0;
    end
    for (int i = 0; i < 500 && done_cnt + to_cnt + err_cnt == 0; i++) @(negedge clk);
    chk("job_end", 32'(done_cnt + to_cnt + err_cnt != 0), 32'd1);
    repeat (3) @(negedge clk);
  endtask
  logic [31:0] exp_addr[5] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'hC};
  logic [31:0] exp_data[5] = '{32'h1000_0000, 32'h2000_0000, 32'h0000_0480, 32'h1, 32'h1};
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_psel", 32'(apb.psel), 32'd0);
    chk("rst_penable", 32'(apb.penable), 32'd0);
    chk("rst_pwrite", 32'(apb.pwrite), 32'd0);
    chk("rst_paddr", apb.paddr, 32'd0);
    chk("rst_pwdata", apb.pwdata, 32'd0);
    chk("rst_ready", 32'(launch_ready), 32'd1);
    chk("rst_pulses", {busy, done, timeout, err}, 32'd0);
    rst = 1'b0;
    run_job(32'h1000_0000, 32'h2000_0000, 32'h0000_0480, 0, 1, 32'hFFFF_FFFF, 1'b0);
    chk("nom_nxfer", 32'(n_xfer), 32'd5);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("nom_addr%0d", i), log_addr[i], exp_addr[i]);
      chk($sformatf("nom_data%0d", i), log_data[i], exp_data[i]);
    end
    chk("nom_done_cyc", 32'(done_cyc), 32'd11);
    chk("nom_done_cnt", 32'(done_cnt), 32'd1);
    chk("nom_other", 32'(to_cnt + err_cnt), 32'd0);
    chk("nom_busy_len", 32'(busy_n), 32'd11);
    chk("nom_ready", 32'(launch_ready), 32'd1);
    run_job(32'h0000_0003, 32'h0000_0005, 32'h0000_04FF, 0, 1, 32'hFFFF_FFFF, 1'b0);
    chk("len_mask", log_data[2], 32'h0000_0480);
    chk("len_src", log_data[0], 32'h0000_0003);
    run_job(32'hA000_0000, 32'hB000_0000, 32'h100, 3, 1, 32'hFFFF_FFFF, 1'b0);
    chk("ws_done_cyc", 32'(done_cyc), 32'd26);
    chk("ws_unstable", 32'(unstable), 32'd0);
    chk("ws_nxfer", 32'(n_xfer), 32'd5);
    run_job(32'h1, 32'h2, 32'h80, 0, 3, 32'hFFFF_FFFF, 1'b0);
    chk("poll_reads", 32'(reads), 32'd3);
    chk("poll_ngaps", 32'(ng), 32'd2);
    chk("poll_gap0", 32'(gaps[0]), 32'd4);
    chk("poll_gap1", 32'(gaps[1]), 32'd4);
    chk("poll_done_cnt", 32'(done_cnt), 32'd1);
    chk("poll_done_cyc", 32'(done_cyc), 32'd23);
    run_job(32'h1, 32'h2, 32'h80, 0, 0, 32'hFFFF_FFFF, 1'b1);
    chk("to_reads", 32'(reads), 32'd5);
    chk("to_nxfer", 32'(n_xfer), 32'd9);
    chk("to_cnt", 32'(to_cnt), 32'd1);
    chk("to_cyc", 32'(to_cyc), 32'd35);
    chk("to_no_done", 32'(done_cnt), 32'd0);
    run_job(32'h1, 32'h2, 32'h80, 0, 1, 32'h8, 1'b0);
    chk("err_cnt", 32'(err_cnt), 32'd1);
    chk("err_cyc", 32'(err_cyc), 32'd7);
    chk("err_nxfer", 32'(n_xfer), 32'd3);
    chk("err_no_done", 32'(done_cnt + to_cnt), 32'd0);
    chk("err_ready", 32'(launch_ready), 32'd1);
    @(negedge clk);
    src = 32'h5; dst = 32'h6; len = 32'h80; done_on = 1; err_addr = 32'hFFFF_FFFF; launch_valid = 1'b1;
    @(negedge clk);
    launch_valid = 1'b0;
    for (int i = 0; i < 20 && !(apb.psel && apb.penable && apb.paddr == 32'h4); i++) @(negedge clk);
    chk("rst_reach_dst", 32'(apb.psel && apb.penable && apb.paddr == 32'h4), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_psel", 32'(apb.psel), 32'd0);
    chk("arst_penable", 32'(apb.penable), 32'd0);
    chk("arst_ready", 32'(launch_ready), 32'd1);
    chk("arst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/aidc_lite_comp_drv.md
# aidc_lite_comp_drv

APB initiator that programs and runs one AIDC-Lite compression job per launch request. It sits between a local controller (or test sequencer) and the compressor's APB configuration port. It writes the source address, destination address, length and start registers, then polls the status register until `done` reads 1. It reports completion, timeout or bus error as single-cycle pulses.

## Interface
Parameters:
- `POLL_GAP`, 16: idle cycles (PSEL low) between consecutive status reads; legal 0..255.
- `MAX_POLLS`, 0: maximum status reads returning done=0 before timeout; 0 = never time out.

Ports:
- `clk`  in  1  sole clock.
- `rst`  in  1  asynchronous, active-high reset.
- `apb_if`  APB_INTF.master  —  drives psel, penable, pwrite, paddr[31:0], pwdata[31:0]; samples prdata[31:0], pready, pslverr.
- `launch_valid_i`  in  1  job request.
- `launch_ready_o`  out  1  high only in IDLE.
- `src_addr_i`  in  32  source byte address; captured on launch.
- `dst_addr_i`  in  32  destination byte address; captured on launch.
- `len_i`  in  32  byte length; captured on launch; bits [6:0] forced to 0 when written.
- `busy_o`  out  1  high from the cycle after launch until the cycle of the terminating pulse (inclusive).
- `done_o`  out  1  pulse: status read returned done=1.
- `timeout_o`  out  1  pulse: MAX_POLLS reads exhausted.
- `err_o`  out  1  pulse: pslverr seen on a completing transfer.

## Operation
- Register map (byte offsets): SRC 0x00, DST 0x04, LEN 0x08, CTRL/STAT 0x0C. Writing CTRL with bit0=1 starts the job. Reading STAT returns done in bit0.
- Launch handshake: launch_valid_i & launch_ready_o. Inputs are captured on this edge; later input changes are ignored.
- Sequence steps: WR_SRC, WR_DST, WR_LEN, WR_START (pwdata=32'h1), RD_STAT.
- FSM states:
  - IDLE: on handshake, go to SETUP.
  - SETUP: psel=1, penable=0; go to ACCESS.
  - ACCESS: psel=1, penable=1; stay while pready=0.
  - GAP: psel=0; stay POLL_GAP cycles.
- On ACCESS & pready:
  - pslverr=1: err_o, go to IDLE.
  - Write steps: advance the step and go to SETUP (back-to-back, psel held high).
  - RD_STAT with prdata[0]=1: done_o, go to IDLE.
  - RD_STAT with prdata[0]=0: increment the poll counter.
    - Counter == MAX_POLLS (MAX_POLLS≠0): timeout_o, go to IDLE.
    - Otherwise: go to GAP, or SETUP directly if POLL_GAP=0.
- paddr, pwrite and pwdata are stable from SETUP through the completing ACCESS cycle. They are zero in IDLE and GAP.
- The compressor clears done on the start write, so the first status read cannot see stale done.
- Poll counter: 16 bits, saturating, cleared on launch.
- Reset values: psel, penable, pwrite, paddr, pwdata, busy_o, done_o, timeout_o, err_o all 0; launch_ready_o 1; FSM IDLE.
- Reset mid-transfer: psel and penable drop asynchronously. No recovery or retry is attempted.

## Timing
- Cycle 0 = launch handshake edge. Zero wait states:
  - SETUP WR_SRC at cycle 1; ACCESS at 2.
  - WR_DST at 3/4; WR_LEN at 5/6; WR_START at 7/8.
  - RD_STAT at 9/10.
  - done_o at cycle 11 if done=1.
  - launch_ready_o high at cycle 11 (in IDLE after the pulse).
- Each pready=0 cycle adds one cycle.
- Each failed poll adds POLL_GAP + 2 cycles.
- Outputs are registered; the terminating pulses last exactly one cycle. At most one terminating pulse is raised per job.
- launch_valid_i while busy is ignored (ready low). A new launch is accepted the cycle after return to IDLE at the earliest.

## Structure
- Package `aidc_lite_comp_pkg`:
  - register offset localparams;
  - state enum (IDLE, SETUP, ACCESS, GAP);
  - step enum (WR_SRC..RD_STAT).
- Sub-module `aidc_lite_apb_master`: generic single-transfer APB initiator with req/ack, addr, write and wdata inputs, and rdata/slverr outputs; owns SETUP/ACCESS.
- Top level `aidc_lite_comp_drv` owns the step sequencer, poll counter, gap timer and pulse generation.

## Test plan
- Nominal: launch src=0x1000_0000, dst=0x2000_0000, len=0x0000_0480; slave done=1 on first read → writes 0x00/0x04/0x08/0x0C with data 0x1000_0000/0x2000_0000/0x0000_0480/0x1; done_o at cycle 11.
- len_i=0x0000_04FF → LEN write data 0x0000_0480.
- Wait states: pready low 3 cycles per transfer → done_o at cycle 26; paddr and pwdata stable throughout each ACCESS.
- Polling: POLL_GAP=4; done=1 on 3rd read → psel low exactly 4 cycles between reads; done_o once.
- Timeout: MAX_POLLS=5, done stuck 0 → 5 reads, timeout_o at the cycle after the 5th ACCESS, no done_o.
- pslverr on WR_LEN → err_o pulse, no START write issued, IDLE. A separate run asserts rst during ACCESS of WR_DST → psel=0 immediately, launch_ready_o=1.
